// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response handshakes and ALU port bundle for alu_share_arbiter
interface alu_share_arbiter_if #(parameter int DATA_WIDTH = 32, parameter int CTRL_WIDTH = 4);
    logic                  req_valid0, req_valid1, req_ready0, req_ready1;
    logic [DATA_WIDTH-1:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
    logic [CTRL_WIDTH-1:0] req_ctrl0, req_ctrl1;
    logic [DATA_WIDTH-1:0] alu_operand1, alu_operand2, alu_out, resp_data;
    logic [CTRL_WIDTH-1:0] alu_contrl;
    logic                  resp_valid0, resp_valid1, resp_ready0, resp_ready1, busy;
    modport master (
        output req_valid0, req_valid1, req_op1_0, req_op1_1, req_op2_0, req_op2_1, req_ctrl0, req_ctrl1,
        output alu_out, resp_ready0, resp_ready1,
        input  req_ready0, req_ready1, alu_operand1, alu_operand2, alu_contrl,
        input  resp_valid0, resp_valid1, resp_data, busy
    );
    modport slave (
        input  req_valid0, req_valid1, req_op1_0, req_op1_1, req_op2_0, req_op2_1, req_ctrl0, req_ctrl1,
        input  alu_out, resp_ready0, resp_ready1,
        output req_ready0, req_ready1, alu_operand1, alu_operand2, alu_contrl,
        output resp_valid0, resp_valid1, resp_data, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters, round-robin on ties.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input logic clk,
    input logic rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state;
    logic                  grant, grant_id, hs, resp_done;
    logic [DATA_WIDTH-1:0] win_op1, win_op2;
    logic [CTRL_WIDTH-1:0] win_ctrl;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = !bus.req_valid0;
`else
    logic last_grant;
    assign grant = (bus.req_valid0 && bus.req_valid1) ? !last_grant : bus.req_valid1;
`endif
    assign bus.req_ready0 = !rst && state == IDLE && !grant && bus.req_valid0;
    assign bus.req_ready1 = !rst && state == IDLE && grant && bus.req_valid1;
    assign hs        = bus.req_ready0 || bus.req_ready1;
    assign win_op1   = grant ? bus.req_op1_1 : bus.req_op1_0;
    assign win_op2   = grant ? bus.req_op2_1 : bus.req_op2_0;
    assign win_ctrl  = grant ? bus.req_ctrl1 : bus.req_ctrl0;
    // only the granted channel's ready can complete the response
    assign resp_done = grant_id ? bus.resp_ready1 : bus.resp_ready0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            grant_id         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant       <= 1'b1;
`endif
            bus.alu_operand1 <= '0;
            bus.alu_operand2 <= '0;
            bus.alu_contrl   <= '0;
            bus.resp_data    <= '0;
            bus.resp_valid0  <= 1'b0;
            bus.resp_valid1  <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    bus.alu_operand1 <= win_op1;
                    bus.alu_operand2 <= win_op2;
                    bus.alu_contrl   <= win_ctrl;
                    grant_id         <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant       <= grant;
`endif
                    bus.busy         <= 1'b1;
                    state            <= EXEC;
                end
                EXEC: begin
                    bus.resp_data   <= bus.alu_out;
                    bus.resp_valid0 <= !grant_id;
                    bus.resp_valid1 <= grant_id;
                    state           <= RESP;
                end
                RESP: if (resp_done) begin
                    bus.resp_valid0 <= 1'b0;
                    bus.resp_valid1 <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0, checks = 0;
    logic [31:0] exp0, exp1;
    typedef struct {bit id; logic [31:0] data;} exp_t;
    exp_t sbq[$];
    int   hs_id[$], hs_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_share_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus();
    alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always_comb begin
        bus.alu_out = 32'h0;
        case (bus.alu_contrl)
            ADD:  bus.alu_out = bus.alu_operand1 + bus.alu_operand2;
            SUB:  bus.alu_out = bus.alu_operand1 - bus.alu_operand2;
            SLL:  bus.alu_out = bus.alu_operand1 << bus.alu_operand2[4:0];
            SLT:  bus.alu_out = {31'b0, $signed(bus.alu_operand1) < $signed(bus.alu_operand2)};
            SLTU: bus.alu_out = {31'b0, bus.alu_operand1 < bus.alu_operand2};
            default: bus.alu_out = 32'h0;
        endcase
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // scoreboard: push on request handshake, pop on response handshake
    always @(negedge clk) begin
        if (rst) sbq.delete();
        else begin
            chk("one_ready", {31'b0, bus.req_ready0 & bus.req_ready1}, 0);
            chk("one_resp_valid", {31'b0, bus.resp_valid0 & bus.resp_valid1}, 0);
            if (bus.req_valid0 && bus.req_ready0) begin
                sbq.push_back('{1'b0, exp0}); hs_id.push_back(0); hs_cyc.push_back(cyc);
            end
            if (bus.req_valid1 && bus.req_ready1) begin
                sbq.push_back('{1'b1, exp1}); hs_id.push_back(1); hs_cyc.push_back(cyc);
            end
            if ((bus.resp_valid0 && bus.resp_ready0) || (bus.resp_valid1 && bus.resp_ready1)) begin
                if (sbq.size() == 0) chk("unexpected_resp", bus.resp_data, 32'hxxxxxxxx);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_id", {31'b0, bus.resp_valid1}, {31'b0, e.id});
                    chk("resp_data", bus.resp_data, e.data);
                end
            end
        end
    end

    task automatic wait_ready(input bit id);
        int n = 0;
        @(negedge clk);
        while (!(id ? bus.req_ready1 : bus.req_ready0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(id ? "hs_wait1" : "hs_wait0", {31'b0, n < 50}, 1);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'b0, n < 20}, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic [31:0] e);
        if (id) begin
            bus.req_op1_1 = a; bus.req_op2_1 = b; bus.req_ctrl1 = c; exp1 = e;
        end else begin
            bus.req_op1_0 = a; bus.req_op2_0 = b; bus.req_ctrl0 = c; exp0 = e;
        end
    endtask

    // returns in the EXEC cycle, #1 after the edge that followed the handshake
    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic [31:0] e);
        set_req(id, a, b, c, e);
        if (id) bus.req_valid1 = 1'b1; else bus.req_valid0 = 1'b1;
        wait_ready(id);
        @(posedge clk); #1;
        if (id) bus.req_valid1 = 1'b0; else bus.req_valid0 = 1'b0;
    endtask

    task automatic wait_hs_count(input int target);
        int n = 0;
        while (hs_id.size() < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("hs_count", {31'b0, n < 60}, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int exp_ids[5];
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0, 1};
`else
        exp_ids = '{0, 1, 0, 1, 1};
`endif
        bus.req_valid0 = 0; bus.req_valid1 = 0;
        bus.resp_ready0 = 1; bus.resp_ready1 = 1;
        set_req(0, 0, 0, ADD, 0);
        set_req(1, 0, 0, ADD, 0);
        #1 rst = 1'b1;
        bus.req_valid0 = 1'b1;
        @(negedge clk);
        chk("rst_req_ready0", {31'b0, bus.req_ready0}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_resp_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, 0);
        chk("rst_alu_op1", bus.alu_operand1, 0);
        chk("rst_alu_op2", bus.alu_operand2, 0);
        chk("rst_alu_ctrl", {28'b0, bus.alu_contrl}, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        bus.req_valid0 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // single op
        issue(0, 32'h5, 32'h3, ADD, 32'h8);
        @(negedge clk);
        chk("exec_op1", bus.alu_operand1, 32'h5);
        chk("exec_op2", bus.alu_operand2, 32'h3);
        chk("exec_ctrl", {28'b0, bus.alu_contrl}, {28'b0, ADD});
        chk("exec_busy", {31'b0, bus.busy}, 1);
        @(negedge clk);
        chk("t2_resp_valid0", {31'b0, bus.resp_valid0}, 1);
        chk("t2_resp_valid1", {31'b0, bus.resp_valid1}, 0);
        chk("t2_resp_data", bus.resp_data, 32'h8);
        drain();

        // signed vs unsigned compare on requester 1
        issue(1, 32'hFFFFFFFF, 32'h1, SLT, 32'h1);
        drain();
        issue(1, 32'hFFFFFFFF, 32'h1, SLTU, 32'h0);
        drain();

        // continuous tie
        hs_id.delete(); hs_cyc.delete();
        set_req(0, 32'd10, 32'd4, SUB, 32'h6);
        set_req(1, 32'd1, 32'd4, SLL, 32'h10);
        bus.req_valid0 = 1'b1; bus.req_valid1 = 1'b1;
        wait_hs_count(4);
        bus.req_valid0 = 1'b0;
        wait_hs_count(5);
        bus.req_valid1 = 1'b0;
        drain();
        chk("tie_hs_total", hs_id.size(), 5);
        for (int i = 0; i < 5 && i < hs_id.size(); i++) begin
            chk($sformatf("tie_grant%0d", i), hs_id[i], exp_ids[i]);
            if (i > 0) chk($sformatf("tie_interval%0d", i), hs_cyc[i] - hs_cyc[i-1], 3);
        end

        // response backpressure with requester 1 waiting
        set_req(0, 32'h100, 32'h23, ADD, 32'h123);
        set_req(1, 32'd20, 32'd5, SUB, 32'd15);
        bus.resp_ready0 = 1'b0;
        bus.req_valid0 = 1'b1; bus.req_valid1 = 1'b1;
        wait_ready(0);
        @(posedge clk); #1 bus.req_valid0 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid0", {31'b0, bus.resp_valid0}, 1);
            chk("bp_resp_data", bus.resp_data, 32'h123);
            chk("bp_req_ready1", {31'b0, bus.req_ready1}, 0);
        end
        @(posedge clk); #1 bus.resp_ready0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_grant1_next", {31'b0, bus.req_ready1}, 1);
        @(posedge clk); #1 bus.req_valid1 = 1'b0;
        drain();

        // reset during EXEC
        issue(0, 32'h1, 32'h1, ADD, 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_resp_valid", {30'b0, bus.resp_valid1, bus.resp_valid0}, 0);
        chk("mid_rst_alu_op1", bus.alu_operand1, 0);
        chk("mid_rst_alu_ctrl", {28'b0, bus.alu_contrl}, 0);
        chk("mid_rst_resp_data", bus.resp_data, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        set_req(0, 32'h2, 32'h3, ADD, 32'h5);
        set_req(1, 32'h9, 32'h2, SUB, 32'h7);
        base = hs_id.size();
        bus.req_valid0 = 1'b1; bus.req_valid1 = 1'b1;
        wait_hs_count(base + 1);
        bus.req_valid0 = 1'b0; bus.req_valid1 = 1'b0;
        drain();
        if (hs_id.size() > base) chk("post_rst_first_grant", hs_id[base], 0);
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
